t_ff_counter: RTL and testbench

//   Parametrised modulo-N up/down counter built from a bank of WIDTH toggle

---
 rtl/t_ff_pkg.sv | 18 +
 rtl/t_ff_counter_if.sv | 28 ++
 rtl/t_ff_cell.sv | 34 +++
 rtl/t_ff_counter.sv | 98 +++++++++
 tb/tb_t_ff_counter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/t_ff_pkg.sv
// ----------------------------------------------------------------------------
// t_ff_pkg
//   Definitions shared by the lab counters.
//   DIR_UP / DIR_DOWN : values of the count-direction input.
//   clamp_mod()       : clamps a value into the range 0..modulus-1. Any value
//                       at or above the modulus becomes modulus-1.
// ----------------------------------------------------------------------------
package t_ff_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   function automatic int unsigned clamp_mod(input int unsigned val,
                                             input int unsigned modulus);
      return (val >= modulus) ? (modulus - 1) : val;
   endfunction

endpackage

// File: rtl/t_ff_counter_if.sv
// ----------------------------------------------------------------------------
// t_ff_counter_if
//   Control and status bundle for t_ff_counter.
//   master (the user of the counter) drives : en, up, load, load_val
//   slave  (the counter) drives             : Q, Q_b, tc, wrap
// ----------------------------------------------------------------------------
interface t_ff_counter_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] Q;
   logic [WIDTH-1:0] Q_b;
   logic             tc;
   logic             wrap;

   modport master (
      output en, up, load, load_val,
      input  Q, Q_b, tc, wrap
   );

   modport slave (
      input  en, up, load, load_val,
      output Q, Q_b, tc, wrap
   );
endinterface

// File: rtl/t_ff_cell.sv
// ----------------------------------------------------------------------------
// t_ff_cell
//   A single toggle flip-flop with asynchronous active-low reset.
//   Clk   : clock, rising edge
//   rst_n : asynchronous reset, active low; forces Q to INIT
//   T     : toggle request; Q inverts on the next rising edge when T=1
//   Q     : stored bit
//   Q_b   : complement of the stored bit. It is taken from the same flop, so
//           it can never disagree with Q.
// ----------------------------------------------------------------------------
module t_ff_cell #(
   parameter logic INIT = 1'b0
) (
   input  logic Clk,
   input  logic rst_n,
   input  logic T,
   output logic Q,
   output logic Q_b
);

   logic q_q;

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= INIT;
      end else begin
         q_q <= q_q ^ T;
      end
   end

   assign Q   = q_q;
   assign Q_b = ~q_q;

endmodule

// File: rtl/t_ff_counter.sv
// ----------------------------------------------------------------------------
// t_ff_counter
//   Modulo-MODULUS up/down counter built from WIDTH toggle cells.
//   Clk   : clock, rising edge
//   rst_n : asynchronous reset, active low
//   bus   : t_ff_counter_if.slave
//           en/up/load/load_val in; Q/Q_b (registered), tc (comb), wrap (reg) out
//   Priority on each edge: load (clamped to MODULUS-1) > en (count) > hold.
// ----------------------------------------------------------------------------
module t_ff_counter
   import t_ff_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int MODULUS   = 16,
   parameter int RESET_VAL = 0
) (
   input  logic           Clk,
   input  logic           rst_n,
   t_ff_counter_if.slave  bus
);

   if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("t_ff_counter: MODULUS must be in 2..2**WIDTH");
   end
   if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
      $error("t_ff_counter: RESET_VAL must be below MODULUS");
   end
   if ($bits(bus.load_val) != WIDTH) begin : g_bad_if_width
      $error("t_ff_counter: interface WIDTH differs from counter WIDTH");
   end

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);

   logic [WIDTH-1:0] q_w;
   logic [WIDTH-1:0] qb_w;
   logic [WIDTH-1:0] next_d;
   logic [WIDTH-1:0] t_vec;
   logic             wrap_d;
   logic             wrap_q;

   always_comb begin
      next_d = q_w;
      wrap_d = 1'b0;
      if (bus.load) begin
         next_d = WIDTH'(clamp_mod(32'(bus.load_val), MODULUS));
      end else if (bus.en) begin
         if (bus.up == DIR_UP) begin
            if (q_w == MAX_VAL) begin
               next_d = '0;
               wrap_d = 1'b1;
            end else begin
               next_d = q_w + 1'b1;
            end
         end else begin
            if (q_w == '0) begin
               next_d = MAX_VAL;
               wrap_d = 1'b1;
            end else begin
               next_d = q_w - 1'b1;
            end
         end
      end
   end

   // Each cell is toggled exactly where the next value differs from the
   // current one; when holding, the toggle vector is all zeros.
   assign t_vec = q_w ^ next_d;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      t_ff_cell #(
         .INIT (RST_VEC[gi])
      ) u_cell (
         .Clk   (Clk),
         .rst_n (rst_n),
         .T     (t_vec[gi]),
         .Q     (q_w[gi]),
         .Q_b   (qb_w[gi])
      );
   end

   always_ff @(posedge Clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap_q <= 1'b0;
      end else begin
         wrap_q <= wrap_d;
      end
   end

   // tc flags the edge on which a count would wrap, one cycle before Q shows
   // the wrapped value.
   assign bus.tc   = bus.en & ~bus.load &
                     ((bus.up == DIR_UP) ? (q_w == MAX_VAL) : (q_w == '0));
   assign bus.Q    = q_w;
   assign bus.Q_b  = qb_w;
   assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_t_ff_counter.sv
// ----------------------------------------------------------------------------
// tb_t_ff_counter
//   Two counters on common stimulus: A (WIDTH=4, MODULUS=10) and
//   B (WIDTH=4, MODULUS=16). Directed vectors with hand-computed results.
// ----------------------------------------------------------------------------
module tb_t_ff_counter;

   typedef struct {
      logic       load;
      logic       en;
      logic       up;
      logic [3:0] lv;
      logic       tc;
      logic [3:0] q;
      logic       wrap;
   } vec_t;

   logic       Clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = 4'd0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   t_ff_counter_if #(.WIDTH(4)) bus_a ();
   t_ff_counter_if #(.WIDTH(4)) bus_b ();

   assign bus_a.en = en;   assign bus_a.up = up;
   assign bus_a.load = load; assign bus_a.load_val = load_val;
   assign bus_b.en = en;   assign bus_b.up = up;
   assign bus_b.load = load; assign bus_b.load_val = load_val;

   t_ff_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(0)) dut_a (
      .Clk   (Clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   t_ff_counter #(.WIDTH(4), .MODULUS(16), .RESET_VAL(0)) dut_b (
      .Clk   (Clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Invariants in every cycle, including while reset is held.
   always @(negedge Clk) begin
      check("a_qb_is_not_q", {28'd0, bus_a.Q_b}, {28'd0, ~bus_a.Q});
      check("a_q_in_range", {31'd0, (bus_a.Q < 4'd10)}, 32'd1);
      check("b_qb_is_not_q", {28'd0, bus_b.Q_b}, {28'd0, ~bus_b.Q});
   end

   // Called just after a falling edge: drive, check tc, check Q/wrap after edge.
   task automatic apply(input vec_t v, input bit on_b, input int idx);
      logic       tc_s, wr_s;
      logic [3:0] q_s;
      load = v.load; en = v.en; up = v.up; load_val = v.lv;
      #1;
      tc_s = on_b ? bus_b.tc : bus_a.tc;
      check($sformatf("%s_tc[%0d]", on_b ? "b" : "a", idx), {31'd0, tc_s}, {31'd0, v.tc});
      @(posedge Clk); #1;
      q_s  = on_b ? bus_b.Q : bus_a.Q;
      wr_s = on_b ? bus_b.wrap : bus_a.wrap;
      check($sformatf("%s_q[%0d]", on_b ? "b" : "a", idx), {28'd0, q_s}, {28'd0, v.q});
      check($sformatf("%s_wrap[%0d]", on_b ? "b" : "a", idx), {31'd0, wr_s}, {31'd0, v.wrap});
      $display("[TB] %s vec %0d: load=%0b en=%0b up=%0b lv=%0d -> q=%0d tc=%0b wrap=%0b",
               on_b ? "B" : "A", idx, v.load, v.en, v.up, v.lv, q_s, tc_s, wr_s);
      @(negedge Clk);
   endtask

   // Reset asserted between edges; outputs must clear without a clock edge.
   task automatic mid_reset(input string tag);
      load = 1'b0; en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_q"},    {28'd0, bus_a.Q},    32'd0);
      check({tag, "_qb"},   {28'd0, bus_a.Q_b},  32'hF);
      check({tag, "_wrap"}, {31'd0, bus_a.wrap}, 32'd0);
      $display("[TB] %s: async reset -> q=%0d qb=%0h wrap=%0b", tag, bus_a.Q, bus_a.Q_b, bus_a.wrap);
      #1 rst_n = 1'b1;
      en = 1'b1; up = 1'b1;
      @(posedge Clk); #1;
      check({tag, "_resume"}, {28'd0, bus_a.Q}, 32'd1);
      @(negedge Clk);
   endtask

   vec_t tab_a[32];
   vec_t tab_b[4];

   initial begin
      // {load, en, up, load_val, tc, q, wrap}
      tab_a[0]  = '{0,1,1,0, 0,1,0};
      tab_a[1]  = '{0,1,1,0, 0,2,0};
      tab_a[2]  = '{0,1,1,0, 0,3,0};
      tab_a[3]  = '{0,1,1,0, 0,4,0};
      tab_a[4]  = '{0,1,1,0, 0,5,0};
      tab_a[5]  = '{0,1,1,0, 0,6,0};
      tab_a[6]  = '{0,1,1,0, 0,7,0};
      tab_a[7]  = '{0,1,1,0, 0,8,0};
      tab_a[8]  = '{0,1,1,0, 0,9,0};
      tab_a[9]  = '{0,1,1,0, 1,0,1};
      tab_a[10] = '{0,1,1,0, 0,1,0};
      tab_a[11] = '{0,1,1,0, 0,2,0};
      tab_a[12] = '{1,0,1,1, 0,1,0};
      tab_a[13] = '{0,1,0,0, 0,0,0};
      tab_a[14] = '{0,1,0,0, 1,9,1};
      tab_a[15] = '{0,1,0,0, 0,8,0};
      tab_a[16] = '{1,1,1,7, 0,7,0};
      tab_a[17] = '{1,1,1,12,0,9,0};
      tab_a[18] = '{1,1,1,3, 0,3,0};
      tab_a[19] = '{1,0,0,15,0,9,0};
      tab_a[20] = '{1,0,1,10,0,9,0};
      tab_a[21] = '{1,0,1,5, 0,5,0};
      tab_a[22] = '{0,0,1,0, 0,5,0};
      tab_a[23] = '{0,0,0,0, 0,5,0};
      tab_a[24] = '{0,0,1,0, 0,5,0};
      tab_a[25] = '{0,0,0,0, 0,5,0};
      tab_a[26] = '{0,0,1,0, 0,5,0};
      tab_a[27] = '{1,0,1,9, 0,9,0};
      tab_a[28] = '{0,0,1,0, 0,9,0};
      tab_a[29] = '{0,1,1,0, 1,0,1};
      tab_a[30] = '{0,0,1,0, 0,0,0};
      tab_a[31] = '{0,1,0,0, 1,9,1};

      tab_b[0]  = '{1,0,1,14,0,14,0};
      tab_b[1]  = '{0,1,1,0, 0,15,0};
      tab_b[2]  = '{0,1,1,0, 1,0,1};
      tab_b[3]  = '{0,1,0,0, 1,15,1};

      // Reset state while rst_n is held low.
      @(negedge Clk); @(negedge Clk);
      #1;
      check("rst_q",    {28'd0, bus_a.Q},    32'd0);
      check("rst_qb",   {28'd0, bus_a.Q_b},  32'hF);
      check("rst_wrap", {31'd0, bus_a.wrap}, 32'd0);
      check("rst_tc",   {31'd0, bus_a.tc},   32'd0);
      check("rst_b_q",  {28'd0, bus_b.Q},    32'd0);
      @(negedge Clk);
      rst_n = 1'b1;

      for (int i = 0; i < 32; i++) apply(tab_a[i], 1'b0, i);

      // Reset while wrap is high (Q=9 after the last vector).
      mid_reset("rst_wrapping");

      // Reset mid-count at Q=6.
      apply('{1,0,1,6, 0,6,0}, 1'b0, 100);
      mid_reset("rst_q6");

      for (int i = 0; i < 4; i++) apply(tab_b[i], 1'b1, i);

      load = 1'b0; en = 1'b0;
      @(negedge Clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
